// File: rtl/ibex_bp_resolve_ctrl.sv
// Branch prediction resolve controller: in-order queue of fetch predictions,
// checked against EX outcomes, with a held redirect on mispredict.
module ibex_bp_resolve_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             pred_valid_i,
  output logic             pred_ready_o,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_pc_i,
  input  logic [31:0]      pred_target_i,
  input  logic             pred_compr_i,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic [CNT_W-1:0] cnt_pred_o,
  output logic [CNT_W-1:0] cnt_mispred_o,
  output logic             err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
    logic        compr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW:0]      rd_q;
  logic [AW:0]      wr_q;
  logic [0:0]       state_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] cnt_pred_q;
  logic [CNT_W-1:0] cnt_mispred_q;
  logic             err_q;

  logic   run;
  logic   empty;
  logic   full;
  logic   push;
  logic   resolve;
  logic   mispred;
  logic   err_set;
  entry_t head;
  logic [31:0] correct_pc;

  assign run   = (state_q == ST_RUN);
  assign empty = (rd_q == wr_q);
  // Wrap bits differ while the index bits match: every slot is occupied.
  assign full  = (rd_q[AW] != wr_q[AW]) &&
                 (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  assign pred_ready_o = run & ~full;

  assign resolve = run & res_valid_i & ~empty & ~flush_i;
  assign err_set = run & res_valid_i & empty & ~flush_i;

  always_comb begin
    mispred = 1'b0;
    if (resolve) begin
      mispred = (head.taken != res_taken_i) ||
                (head.taken && res_taken_i &&
                 (head.target != res_target_i));
    end
  end

  always_comb begin
    correct_pc = head.pc + (head.compr ? 32'd2 : 32'd4);
    if (res_taken_i) correct_pc = res_target_i;
  end

  // Wrong-path push alongside a mispredict is dropped.
  assign push = pred_valid_i & pred_ready_o & ~flush_i & ~mispred;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= '{
        taken:  pred_taken_i,
        pc:     pred_pc_i,
        target: pred_target_i,
        compr:  pred_compr_i
      };
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      rd_q          <= '0;
      wr_q          <= '0;
      redirect_pc_q <= '0;
      cnt_pred_q    <= '0;
      cnt_mispred_q <= '0;
      err_q         <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_RUN;
      rd_q    <= wr_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mispred) begin
            state_q       <= ST_REDIR;
            redirect_pc_q <= correct_pc;
            rd_q          <= wr_q;
          end else begin
            if (resolve) rd_q <= rd_q + 1'b1;
            if (push)    wr_q <= wr_q + 1'b1;
          end
        end
        ST_REDIR: begin
          if (redirect_ready_i) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
      if (resolve && (cnt_pred_q != '1)) begin
        cnt_pred_q <= cnt_pred_q + 1'b1;
      end
      if (mispred && (cnt_mispred_q != '1)) begin
        cnt_mispred_q <= cnt_mispred_q + 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign redirect_o    = (state_q == ST_REDIR);
  assign redirect_pc_o = redirect_pc_q;
  assign cnt_pred_o    = cnt_pred_q;
  assign cnt_mispred_o = cnt_mispred_q;
  assign err_o         = err_q;

endmodule
